switch_event_ctrl: RTL and testbench
====================================

# switch_event_ctrl

Multi-switch debounce scheduler and event controller for the Go Board push-buttons. One shared prescaler paces debounce sampling for all switches. A per-switch state machine turns each debounced level into press, release and long-press events. A round-robin arbiter serializes those events onto a single valid/ready event port, which feeds the LED, display and game logic above it.

## Interface

Parameters:
- c_NUM_SW, 4: number of switches (2..4; event index is 2 bits).
- c_TICK_DIV, 2500: clock cycles per sample tick (100 µs at 25 MHz).
- c_STABLE_TICKS, 100: consecutive disagreeing ticks before the debounced level flips (10 ms).
- c_LONG_TICKS, 5000: ticks held after a press before a long-press event (500 ms).

Ports:
- i_Clk, input, 1: system clock. One clock domain.
- i_Rst_L, input, 1: reset, synchronous and active-low.
- i_Switch, input, c_NUM_SW: raw, asynchronous switch levels (1 = pressed).
- o_Switch, output, c_NUM_SW: debounced levels.
- o_Evt_Valid, output, 1: event available.
- o_Evt_Sw, output, 2: switch index of the event.
- o_Evt_Code, output, 2: event code. 01 = press, 10 = release, 11 = long press.
- i_Evt_Ready, input, 1: consumer accepts the event.
- o_Overrun, output, c_NUM_SW: sticky per-switch flag; an event was dropped.

## Operation

- Input sync: each i_Switch bit passes through a 2-flop synchronizer. Only the synced value is used.
- Prescaler: counts 0..c_TICK_DIV-1 and wraps. The internal tick is high for one cycle when count = c_TICK_DIV-1.
- Debounce, per switch, evaluated on tick cycles only:
  - Synced value ≠ o_Switch: stable counter +1.
  - Synced value = o_Switch: stable counter cleared.
  - Counter reaches c_STABLE_TICKS: o_Switch toggles and the counter clears.
  - Counter width is clog2(c_STABLE_TICKS+1). It never wraps.
- Per-switch FSM:
  - S_IDLE (level 0): rising debounced level → raise a press event, clear the hold counter, go to S_DOWN.
  - S_DOWN (level 1): hold counter +1 per tick. When it reaches c_LONG_TICKS → raise a long-press event, go to S_HELD. Falling level → raise a release event, go to S_IDLE.
  - S_HELD: falling level → raise a release event, go to S_IDLE. The hold counter saturates and no further long events are raised.
  - A release before c_LONG_TICKS produces press then release only.
- Pending store: one entry per switch, holding a valid bit and a code.
  - New event, entry empty → store it.
  - Entry full and not granted this cycle → new event dropped, o_Overrun bit set.
  - Entry granted in the same cycle the new event arrives → new event stored, no overrun.
- Arbiter:
  - Output register is empty (o_Evt_Valid = 0) or accepted this cycle (o_Evt_Valid & i_Evt_Ready) → load the first pending switch, searching round-robin from (last granted + 1) mod c_NUM_SW.
  - On grant: clear that pending entry, update last-granted.
  - No pending entries → o_Evt_Valid drops to 0 after the acceptance.
- Handshake:
  - Transfer occurs when o_Evt_Valid & i_Evt_Ready at a rising edge.
  - While valid and not ready, o_Evt_Sw and o_Evt_Code are held stable.
  - Back-to-back transfers sustain one per cycle.
- o_Overrun clears only on reset.

## Timing

- Reset (i_Rst_L = 0 at an edge) clears everything:
  - Prescaler, synchronizers, all counters.
  - All FSMs to S_IDLE, pending entries empty.
  - o_Switch = 0, o_Evt_Valid = 0, o_Evt_Sw = 0, o_Evt_Code = 00, o_Overrun = 0.
  - Last-granted = c_NUM_SW-1, so switch 0 has first priority.
- Reset mid-operation discards any pending or presented event. No event is emitted on reset release.
- Raw input to synced value: 2 cycles.
- Event raised in tick cycle T: pending visible at T+1, o_Evt_Valid at T+2 if the output register is free.
- Minimum press debounce: c_STABLE_TICKS ticks of stable input. The maximum adds one tick of prescaler phase.
- Long press fires c_LONG_TICKS ticks after the press event's tick.
- Several switches raising events on the same tick:
  - All are stored in the same cycle.
  - They are presented in round-robin order, one per accepted transfer.

## Test plan

Simulation parameters: c_TICK_DIV = 4, c_STABLE_TICKS = 3, c_LONG_TICKS = 10.

1. Bounce rejection: i_Switch[0] toggles every 5 cycles for 60 cycles, then returns to 0 → o_Switch stays 0, no event.
2. Clean short press on switch 1, i_Evt_Ready = 1, held 40 cycles → o_Switch[1] rises, one event {01, 01}; on release, one event {01, 10}; no long event.
3. Long press on switch 2, held 80 cycles → events {10, 01}, then {10, 11} exactly 40 cycles after the press event, then {10, 10} on release.
4. Simultaneous press of switches 0 and 3 on the same tick, ready = 1 → {00, 01} then {11, 01} on consecutive cycles. Repeat with last-granted = 0 → switch 3 is served first.
5. Backpressure: i_Evt_Ready = 0, switch 0 press then release → first event held stable, second stored, third-and-later dropped with o_Overrun[0] = 1. Raise ready → press and release delivered in order.
6. Reset mid-operation: assert i_Rst_L = 0 for 1 cycle while o_Evt_Valid = 1 and switch 1 is in S_DOWN → next cycle all outputs are 0. A held switch re-debounces and produces a fresh press event.

Source files
------------

// File: rtl/switch_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : switch_event_ctrl
// Brief    : Multi-switch debounce scheduler and event controller. A shared
//            prescaler paces debounce sampling, a per-switch FSM turns each
//            debounced level into press / release / long-press events, and a
//            round-robin arbiter serializes them onto one valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module switch_event_ctrl #(
    parameter int c_NUM_SW       = 4,
    parameter int c_TICK_DIV     = 2500,
    parameter int c_STABLE_TICKS = 100,
    parameter int c_LONG_TICKS   = 5000
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic [c_NUM_SW-1:0] i_Switch,
    output logic [c_NUM_SW-1:0] o_Switch,
    output logic                o_Evt_Valid,
    output logic [1:0]          o_Evt_Sw,
    output logic [1:0]          o_Evt_Code,
    input  logic                i_Evt_Ready,
    output logic [c_NUM_SW-1:0] o_Overrun
);

    // Counter widths and terminal values
    localparam int                c_TW          = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
    localparam logic [c_TW-1:0]   c_TICK_LAST   = c_TW'(c_TICK_DIV - 1);
    localparam int                c_SW_W        = $clog2(c_STABLE_TICKS + 1);
    localparam logic [c_SW_W-1:0] c_STABLE_LAST = c_SW_W'(c_STABLE_TICKS);
    localparam int                c_HW          = $clog2(c_LONG_TICKS + 1);
    localparam logic [c_HW-1:0]   c_LONG_LAST   = c_HW'(c_LONG_TICKS);

    // Per-switch FSM states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DOWN = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;

    // Event codes
    localparam logic [1:0] c_EVT_PRESS   = 2'b01;
    localparam logic [1:0] c_EVT_RELEASE = 2'b10;
    localparam logic [1:0] c_EVT_LONG    = 2'b11;

    // Last-granted after reset: makes switch 0 the first candidate
    localparam logic [1:0] c_LAST_INIT = 2'(c_NUM_SW - 1);

    logic [c_NUM_SW-1:0] r_Sync1;
    logic [c_NUM_SW-1:0] r_Sync2;
    logic [c_NUM_SW-1:0] r_Switch;
    logic [c_NUM_SW-1:0] r_Overrun;
    logic [c_NUM_SW-1:0] r_Pend_Valid;
    logic [1:0]          r_Pend_Code  [c_NUM_SW];
    logic [c_SW_W-1:0]   r_Stable_Cnt [c_NUM_SW];
    logic [c_HW-1:0]     r_Hold_Cnt   [c_NUM_SW];
    logic [1:0]          r_State      [c_NUM_SW];
    logic [c_TW-1:0]     r_Tick_Cnt;
    logic [1:0]          r_Last;
    logic                r_Evt_Valid;
    logic [1:0]          r_Evt_Sw;
    logic [1:0]          r_Evt_Code;

    logic                w_Tick;
    logic [c_NUM_SW-1:0] w_Toggle;
    logic [c_NUM_SW-1:0] w_Evt_New;
    logic [1:0]          w_Evt_Code [c_NUM_SW];
    logic [c_NUM_SW-1:0] w_Grant_Vec;
    logic [2:0]          w_Cand;
    logic [1:0]          w_Gnt_Idx;
    logic                w_Found;
    logic                w_Load;
    logic                w_Grant;

    assign w_Tick      = (r_Tick_Cnt == c_TICK_LAST);
    assign w_Load      = !r_Evt_Valid || i_Evt_Ready;
    assign w_Grant     = w_Load && w_Found;

    assign o_Switch    = r_Switch;
    assign o_Overrun   = r_Overrun;
    assign o_Evt_Valid = r_Evt_Valid;
    assign o_Evt_Sw    = r_Evt_Sw;
    assign o_Evt_Code  = r_Evt_Code;

    // Two-flop synchronizer on every raw switch input
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Sync1 <= '0;
            r_Sync2 <= '0;
        end else begin
            r_Sync1 <= i_Switch;
            r_Sync2 <= r_Sync1;
        end
    end

    // Shared prescaler producing a one-cycle sample tick
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Tick_Cnt <= '0;
        end else if (w_Tick) begin
            r_Tick_Cnt <= '0;
        end else begin
            r_Tick_Cnt <= r_Tick_Cnt + c_TW'(1);
        end
    end

    // Debounced level flips on the tick that completes the stable run
    always_comb begin
        w_Toggle = '0;
        for (int i = 0; i < c_NUM_SW; i++) begin
            w_Toggle[i] = w_Tick && (r_Sync2[i] != r_Switch[i]) &&
                          ((r_Stable_Cnt[i] + c_SW_W'(1)) == c_STABLE_LAST);
        end
    end

    // Stable counters and debounced levels
    always_ff @(posedge i_Clk) begin
        for (int i = 0; i < c_NUM_SW; i++) begin
            if (!i_Rst_L) begin
                r_Stable_Cnt[i] <= '0;
                r_Switch[i]     <= 1'b0;
            end else if (w_Tick) begin
                if (r_Sync2[i] == r_Switch[i]) begin
                    r_Stable_Cnt[i] <= '0;
                end else if (w_Toggle[i]) begin
                    r_Stable_Cnt[i] <= '0;
                    r_Switch[i]     <= ~r_Switch[i];
                end else begin
                    r_Stable_Cnt[i] <= r_Stable_Cnt[i] + c_SW_W'(1);
                end
            end
        end
    end

    // Event generation; a release wins over a long press on the same tick
    always_comb begin
        w_Evt_New = '0;
        for (int i = 0; i < c_NUM_SW; i++) begin
            w_Evt_Code[i] = 2'b00;
            case (r_State[i])
                S_IDLE: begin
                    if (w_Toggle[i] && !r_Switch[i]) begin
                        w_Evt_New[i]  = 1'b1;
                        w_Evt_Code[i] = c_EVT_PRESS;
                    end
                end
                S_DOWN: begin
                    if (w_Toggle[i] && r_Switch[i]) begin
                        w_Evt_New[i]  = 1'b1;
                        w_Evt_Code[i] = c_EVT_RELEASE;
                    end else if (w_Tick && ((r_Hold_Cnt[i] + c_HW'(1)) == c_LONG_LAST)) begin
                        w_Evt_New[i]  = 1'b1;
                        w_Evt_Code[i] = c_EVT_LONG;
                    end
                end
                S_HELD: begin
                    if (w_Toggle[i] && r_Switch[i]) begin
                        w_Evt_New[i]  = 1'b1;
                        w_Evt_Code[i] = c_EVT_RELEASE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-switch press/hold FSM and hold counter
    always_ff @(posedge i_Clk) begin
        for (int i = 0; i < c_NUM_SW; i++) begin
            if (!i_Rst_L) begin
                r_State[i]    <= S_IDLE;
                r_Hold_Cnt[i] <= '0;
            end else begin
                case (r_State[i])
                    S_IDLE: begin
                        if (w_Toggle[i] && !r_Switch[i]) begin
                            r_State[i]    <= S_DOWN;
                            r_Hold_Cnt[i] <= '0;
                        end
                    end
                    S_DOWN: begin
                        if (w_Toggle[i] && r_Switch[i]) begin
                            r_State[i] <= S_IDLE;
                        end else if (w_Tick) begin
                            r_Hold_Cnt[i] <= r_Hold_Cnt[i] + c_HW'(1);
                            if ((r_Hold_Cnt[i] + c_HW'(1)) == c_LONG_LAST) begin
                                r_State[i] <= S_HELD;
                            end
                        end
                    end
                    S_HELD: begin
                        if (w_Toggle[i] && r_Switch[i]) begin
                            r_State[i] <= S_IDLE;
                        end
                    end
                    default: r_State[i] <= S_IDLE;
                endcase
            end
        end
    end

    // Round-robin search starting just after the last granted switch
    always_comb begin
        w_Found   = 1'b0;
        w_Gnt_Idx = 2'd0;
        w_Cand    = 3'd0;
        for (int k = 1; k <= c_NUM_SW; k++) begin
            w_Cand = {1'b0, r_Last} + 3'(k);
            if (w_Cand >= 3'(c_NUM_SW)) begin
                w_Cand = w_Cand - 3'(c_NUM_SW);
            end
            if (!w_Found && r_Pend_Valid[w_Cand[1:0]]) begin
                w_Found   = 1'b1;
                w_Gnt_Idx = w_Cand[1:0];
            end
        end
        w_Grant_Vec = '0;
        for (int i = 0; i < c_NUM_SW; i++) begin
            w_Grant_Vec[i] = w_Grant && (w_Gnt_Idx == 2'(i));
        end
    end

    // Pending store; an entry freed by this cycle's grant may accept a new event
    always_ff @(posedge i_Clk) begin
        for (int i = 0; i < c_NUM_SW; i++) begin
            if (!i_Rst_L) begin
                r_Pend_Valid[i] <= 1'b0;
                r_Pend_Code[i]  <= 2'b00;
                r_Overrun[i]    <= 1'b0;
            end else if (w_Evt_New[i]) begin
                if (!r_Pend_Valid[i] || w_Grant_Vec[i]) begin
                    r_Pend_Valid[i] <= 1'b1;
                    r_Pend_Code[i]  <= w_Evt_Code[i];
                end else begin
                    r_Overrun[i] <= 1'b1;
                end
            end else if (w_Grant_Vec[i]) begin
                r_Pend_Valid[i] <= 1'b0;
            end
        end
    end

    // Output register: reload when empty or when the current event is taken
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Evt_Valid <= 1'b0;
            r_Evt_Sw    <= 2'd0;
            r_Evt_Code  <= 2'b00;
            r_Last      <= c_LAST_INIT;
        end else if (w_Grant) begin
            r_Evt_Valid <= 1'b1;
            r_Evt_Sw    <= w_Gnt_Idx;
            r_Evt_Code  <= r_Pend_Code[w_Gnt_Idx];
            r_Last      <= w_Gnt_Idx;
        end else if (w_Load) begin
            r_Evt_Valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_event_ctrl
// Brief    : Self-checking bench for switch_event_ctrl against a behavioural
//            model of debounce, press/long/release events and round-robin
//            delivery.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_event_ctrl;

    localparam int NSW = 4;
    localparam int TD  = 4;
    localparam int ST  = 3;
    localparam int LT  = 10;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [3:0] sw_in;
    logic [3:0] o_sw;
    logic       ev_valid;
    logic [1:0] ev_sw;
    logic [1:0] ev_code;
    logic       ready;
    logic [3:0] ovr;

    always #5 clk = ~clk;

    switch_event_ctrl #(
        .c_NUM_SW       (NSW),
        .c_TICK_DIV     (TD),
        .c_STABLE_TICKS (ST),
        .c_LONG_TICKS   (LT)
    ) u_dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_Switch    (sw_in),
        .o_Switch    (o_sw),
        .o_Evt_Valid (ev_valid),
        .o_Evt_Sw    (ev_sw),
        .o_Evt_Code  (ev_code),
        .i_Evt_Ready (ready),
        .o_Overrun   (ovr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Behavioural model state
    bit m_s1   [NSW];
    bit m_s2   [NSW];
    bit m_deb  [NSW];
    int m_dis  [NSW];
    int m_hold [NSW];
    bit m_long [NSW];
    int m_pend [NSW];   // 0 = empty, else event code
    bit m_ovr  [NSW];
    bit m_val;
    int m_sw, m_code, m_last, m_phase;

    // Log of transfers as seen by the model
    int lg_cyc  [64];
    int lg_sw   [64];
    int lg_code [64];
    int lg_n;

    task automatic lg_clear();
        lg_n = 0;
        for (int i = 0; i < 64; i++) begin
            lg_cyc[i] = -1; lg_sw[i] = -1; lg_code[i] = -1;
        end
    endtask

    task automatic model_step();
        int  ev [NSW];
        int  g;
        int  idx;
        bit  tick;
        bit  load;
        if (!rst_l) begin
            for (int i = 0; i < NSW; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_dis[i] = 0;
                m_hold[i] = 0; m_long[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
            end
            m_val = 0; m_sw = 0; m_code = 0; m_last = NSW - 1; m_phase = 0;
            return;
        end
        if (m_val && ready && lg_n < 64) begin
            lg_cyc[lg_n] = cyc; lg_sw[lg_n] = m_sw; lg_code[lg_n] = m_code;
            lg_n++;
        end
        tick    = (m_phase == TD - 1);
        m_phase = (m_phase + 1) % TD;
        for (int i = 0; i < NSW; i++) begin
            ev[i] = 0;
            if (tick) begin
                if (m_s2[i] != m_deb[i]) m_dis[i]++;
                else m_dis[i] = 0;
                if (m_dis[i] == ST) begin
                    m_dis[i] = 0;
                    m_deb[i] = !m_deb[i];
                    if (m_deb[i]) begin
                        ev[i] = 1; m_hold[i] = 0; m_long[i] = 0;
                    end else begin
                        ev[i] = 2;
                    end
                end else if (m_deb[i] && !m_long[i]) begin
                    m_hold[i]++;
                    if (m_hold[i] == LT) begin
                        ev[i] = 3; m_long[i] = 1;
                    end
                end
            end
        end
        load = !m_val || ready;
        g = -1;
        if (load) begin
            for (int k = 1; k <= NSW; k++) begin
                idx = (m_last + k) % NSW;
                if (g < 0 && m_pend[idx] != 0) g = idx;
            end
        end
        if (g >= 0) begin
            m_val = 1; m_sw = g; m_code = m_pend[g]; m_last = g; m_pend[g] = 0;
        end else if (load) begin
            m_val = 0;
        end
        for (int i = 0; i < NSW; i++) begin
            if (ev[i] != 0) begin
                if (m_pend[i] == 0) m_pend[i] = ev[i];
                else m_ovr[i] = 1;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = sw_in[i];
        end
    endtask

    task automatic compare();
        logic [3:0] e_sw;
        logic [3:0] e_ovr;
        logic [1:0] e_esw;
        logic [1:0] e_code;
        for (int i = 0; i < NSW; i++) begin
            e_sw[i]  = m_deb[i];
            e_ovr[i] = m_ovr[i];
        end
        e_esw  = 2'(m_sw);
        e_code = 2'(m_code);
        n_tests++;
        if (o_sw !== e_sw || ev_valid !== m_val || ev_sw !== e_esw ||
            ev_code !== e_code || ovr !== e_ovr) begin
            n_fail++;
            $display("FAIL model_cmp cycle %0d: got sw=%b v=%b esw=%0d code=%b ovr=%b, expected sw=%b v=%b esw=%0d code=%b ovr=%b",
                     cyc, o_sw, ev_valid, ev_sw, ev_code, ovr,
                     e_sw, m_val, e_esw, e_code, e_ovr);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step1();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step1();
    endtask

    task automatic do_reset(input int n);
        rst_l = 1'b0;
        run(n);
        rst_l = 1'b1;
    endtask

    initial begin
        rst_l = 1'b0;
        sw_in = 4'b0000;
        ready = 1'b1;
        lg_clear();
        run(3);
        chk("reset_valid", int'(ev_valid), 0);
        chk("reset_level", int'(o_sw), 0);
        chk("reset_code", int'(ev_code), 0);
        chk("reset_ovr", int'(ovr), 0);
        rst_l = 1'b1;
        run(2);

        // Bounce rejection on switch 0
        lg_clear();
        for (int k = 0; k < 12; k++) begin
            sw_in[0] = ~sw_in[0];
            run(5);
        end
        run(20);
        chk("bounce_events", lg_n, 0);
        chk("bounce_level", int'(o_sw), 0);

        // Clean short press on switch 1
        lg_clear();
        sw_in[1] = 1'b1;
        run(40);
        sw_in[1] = 1'b0;
        run(30);
        chk("short_count", lg_n, 2);
        chk("short_sw0", lg_sw[0], 1);
        chk("short_code0", lg_code[0], 1);
        chk("short_sw1", lg_sw[1], 1);
        chk("short_code1", lg_code[1], 2);

        // Long press on switch 2
        lg_clear();
        sw_in[2] = 1'b1;
        run(80);
        sw_in[2] = 1'b0;
        run(30);
        chk("long_count", lg_n, 3);
        chk("long_code0", lg_code[0], 1);
        chk("long_code1", lg_code[1], 3);
        chk("long_code2", lg_code[2], 2);
        chk("long_sw", lg_sw[1], 2);
        chk("long_delay", lg_cyc[1] - lg_cyc[0], 40);

        // Simultaneous press of switches 0 and 3 from reset priority
        do_reset(2);
        lg_clear();
        sw_in = 4'b1001;
        run(20);
        chk("simul_count", lg_n, 2);
        chk("simul_first", lg_sw[0], 0);
        chk("simul_second", lg_sw[1], 3);
        chk("simul_code", lg_code[1], 1);
        chk("simul_spacing", lg_cyc[1] - lg_cyc[0], 1);
        sw_in = 4'b0000;
        run(20);
        sw_in = 4'b0001;
        run(20);
        // last-granted is now switch 0, so switch 3 is served first
        lg_clear();
        sw_in = 4'b1000;
        run(20);
        chk("rr_count", lg_n, 2);
        chk("rr_first_sw", lg_sw[0], 3);
        chk("rr_first_code", lg_code[0], 1);
        chk("rr_second_sw", lg_sw[1], 0);
        chk("rr_second_code", lg_code[1], 2);
        sw_in = 4'b0000;
        run(20);

        // Backpressure and overrun on switch 0
        ready = 1'b0;
        lg_clear();
        sw_in[0] = 1'b1; run(20);
        sw_in[0] = 1'b0; run(20);
        sw_in[0] = 1'b1; run(20);
        sw_in[0] = 1'b0; run(20);
        chk("bp_overrun", int'(ovr), 1);
        chk("bp_valid", int'(ev_valid), 1);
        chk("bp_held_code", int'(ev_code), 1);
        chk("bp_held_sw", int'(ev_sw), 0);
        ready = 1'b1;
        run(10);
        chk("bp_count", lg_n, 2);
        chk("bp_code0", lg_code[0], 1);
        chk("bp_code1", lg_code[1], 2);

        // Reset while an event is presented and switch 1 is down
        ready = 1'b0;
        sw_in[1] = 1'b1;
        run(20);
        chk("rst_pre_valid", int'(ev_valid), 1);
        do_reset(1);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_level", int'(o_sw), 0);
        chk("rst_ovr", int'(ovr), 0);
        chk("rst_code", int'(ev_code), 0);
        lg_clear();
        ready = 1'b1;
        run(30);
        chk("rst_repress_count", lg_n, 1);
        chk("rst_repress_sw", lg_sw[0], 1);
        chk("rst_repress_code", lg_code[0], 1);
        sw_in = 4'b0000;
        run(30);

        // Randomized traffic checked every cycle against the model
        lg_clear();
        for (int r = 0; r < 4000; r++) begin
            if ($urandom_range(0, 14) == 0) begin
                int s;
                s = $urandom_range(0, NSW - 1);
                sw_in[s] = ~sw_in[s];
            end
            ready = ($urandom_range(0, 3) != 0);
            rst_l = ($urandom_range(0, 1499) != 0);
            if (lg_n > 60) lg_clear();
            run(1);
        end
        rst_l = 1'b1;
        run(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
